// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive reader.
// Holds the reader FSM state enum and the FIFO pointer-width helper.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rx_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: head is visible on data_o whenever not empty.
// Ports: clk_i, rst_i (async high), push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH[PW:0]);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_reader.sv
// Captures UART RX bytes into a show-ahead FIFO and pulses Clear_RX_Flag.
// Ports: UART side (DATARX, RX_FLAG, ParityError, Clear_RX_Flag), stream
// (m_data, m_perr, m_valid, m_ready), status (fifo_count, overflow,
// clear_overflow, perr_count). Macro UART_RX_DROP_PERR_EN discards
// parity-error bytes instead of queueing them.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH   = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_LENGTH-1:0]       DATARX,
  input  logic                         RX_FLAG,
  input  logic                         ParityError,
  output logic                         Clear_RX_Flag,
  output logic [WORD_LENGTH-1:0]       m_data,
  output logic                         m_perr,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         clear_overflow,
  output logic [ERR_CNT_WIDTH-1:0]     perr_count
);

  rx_state_e                state_q;
  logic                     overflow_q;
  logic [ERR_CNT_WIDTH-1:0] perr_q;
  logic                     capture, keep, push_req, pop;
  logic                     full, empty, ov_set;
  logic [WORD_LENGTH:0]     head;

  assign capture = (state_q == IDLE) & RX_FLAG;

`ifdef UART_RX_DROP_PERR_EN
  assign keep   = ~ParityError;
  assign m_perr = 1'b0;
`else
  assign keep   = 1'b1;
  assign m_perr = head[WORD_LENGTH];
`endif

  assign push_req = capture & keep;
  assign pop      = ~empty & m_ready;
  assign ov_set   = push_req & full & ~pop;

  uart_rx_fifo #(
    .WIDTH (WORD_LENGTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_req),
    .data_i  ({ParityError, DATARX}),
    .pop_i   (m_ready),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign m_data        = head[WORD_LENGTH-1:0];
  assign m_valid       = ~empty;
  assign Clear_RX_Flag = (state_q == CLEAR);
  assign overflow      = overflow_q;
  assign perr_count    = perr_q;

  // CLEAR ignores RX_FLAG: the UART may still show the byte just taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      perr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE:    if (RX_FLAG) state_q <= CLEAR;
        CLEAR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (ov_set)              overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
      if (capture & ParityError & ~&perr_q)
        perr_q <= perr_q + 1'b1;
    end
  end

endmodule
